// File: rtl/irq_priority_arbiter.sv
// Interrupt priority arbiter: picks the highest-priority eligible pending
// source and presents it to the CPU through a claim/complete handshake. On
// claim it sends a one-hot acknowledge pulse back to the interrupt controller.
// Per-source priorities and a global threshold are CPU-visible registers.
module irq_priority_arbiter #(
    parameter int INTR_WIDTH = 8,
    parameter int PRIO_WIDTH = 3,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(INTR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INTR_WIDTH-1:0] intr_pending,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_write_data,
    output logic [DATA_WIDTH-1:0] cpu_read_data,
    output logic                  irq_req,
    output logic [ID_WIDTH-1:0]   irq_id,
    input  logic                  irq_claim,
    input  logic                  irq_complete,
    input  logic [ID_WIDTH-1:0]   irq_complete_id,
    output logic [INTR_WIDTH-1:0] intr_ack_out
);

    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] IDX_THRESHOLD = WORD_W'(INTR_WIDTH);
    localparam logic [WORD_W-1:0] IDX_STATUS    = WORD_W'(INTR_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARB     = 2'd1,
        S_PRESENT = 2'd2,
        S_SERVICE = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [ID_WIDTH-1:0]     cur_id_reg, cur_id_next;
    logic [PRIO_WIDTH-1:0]   cur_prio_reg, cur_prio_next;
    logic [PRIO_WIDTH-1:0]   prio_reg [INTR_WIDTH];
    logic [PRIO_WIDTH-1:0]   threshold_reg;
    logic [INTR_WIDTH-1:0]   ack_reg, ack_next;
    logic [DATA_WIDTH-1:0]   read_data_reg;
    logic [DATA_WIDTH-1:0]   read_value;

    logic [WORD_W-1:0]       word_index;
    logic [INTR_WIDTH-1:0]   eligible;
    logic                    any_eligible;
    logic [ID_WIDTH-1:0]     win_id;
    logic [PRIO_WIDTH-1:0]   win_prio;

    // Byte-offset bits and unused write-data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = &{1'b0, cpu_address[1:0], cpu_write_data[DATA_WIDTH-1:PRIO_WIDTH]};

    assign word_index = cpu_address[ADDR_WIDTH-1:2];

    // Per-source priority registers and eligibility terms.
    generate
        for (genvar gi = 0; gi < INTR_WIDTH; gi++) begin : g_src
            // Priority register write for this source.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prio_reg[gi] <= '0;
                end else if (cpu_write && word_index == WORD_W'(gi)) begin
                    prio_reg[gi] <= cpu_write_data[PRIO_WIDTH-1:0];
                end
            end

            // A zero priority disables the source regardless of threshold.
            assign eligible[gi] = intr_pending[gi] && (prio_reg[gi] != '0) &&
                                  (prio_reg[gi] > threshold_reg);
        end
    endgenerate

    // Threshold register write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            threshold_reg <= '0;
        end else if (cpu_write && word_index == IDX_THRESHOLD) begin
            threshold_reg <= cpu_write_data[PRIO_WIDTH-1:0];
        end
    end

    assign any_eligible = |eligible;

    // Winner search; scanning downward with >= lets lower indices win ties.
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        for (int i = INTR_WIDTH - 1; i >= 0; i--) begin
            if (eligible[i] && prio_reg[i] >= win_prio) begin
                win_id   = ID_WIDTH'(i);
                win_prio = prio_reg[i];
            end
        end
    end

    // State, current-source and ack registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            cur_id_reg   <= '0;
            cur_prio_reg <= '0;
            ack_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cur_id_reg   <= cur_id_next;
            cur_prio_reg <= cur_prio_next;
            ack_reg      <= ack_next;
        end
    end

    // Next-state logic; a claim takes precedence over preemption.
    always_comb begin
        state_next    = state_reg;
        cur_id_next   = cur_id_reg;
        cur_prio_next = cur_prio_reg;
        ack_next      = '0;
        case (state_reg)
            S_IDLE: begin
                if (any_eligible) state_next = S_ARB;
            end
            S_ARB: begin
                if (any_eligible) begin
                    state_next    = S_PRESENT;
                    cur_id_next   = win_id;
                    cur_prio_next = win_prio;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_PRESENT: begin
                if (irq_claim) begin
                    state_next = S_SERVICE;
                    ack_next   = INTR_WIDTH'(1) << cur_id_reg;
                end else if (any_eligible && win_prio > cur_prio_reg) begin
                    state_next = S_ARB;
                end else if (!eligible[cur_id_reg]) begin
                    state_next = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (irq_complete && irq_complete_id == cur_id_reg) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state so reset drops the request immediately.
    always_comb begin
        irq_req      = (state_reg == S_PRESENT);
        irq_id       = cur_id_reg;
        intr_ack_out = ack_reg;
    end

    // Register read mux.
    always_comb begin
        read_value = '0;
        if (word_index < IDX_THRESHOLD) begin
            read_value[PRIO_WIDTH-1:0] = prio_reg[word_index[ID_WIDTH-1:0]];
        end else if (word_index == IDX_THRESHOLD) begin
            read_value[PRIO_WIDTH-1:0] = threshold_reg;
        end else if (word_index == IDX_STATUS) begin
            read_value[9:8]          = state_reg;
            read_value[ID_WIDTH-1:0] = cur_id_reg;
        end
    end

    // Read data is captured on a read strobe and held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_reg <= '0;
        end else if (cpu_read) begin
            read_data_reg <= read_value;
        end
    end

    assign cpu_read_data = read_data_reg;

endmodule
